// File: rtl/hello_pkg.sv
// Shared character codes, segment patterns and reset message for hello_scroller.
// Segment constants are active low, bit0 = a .. bit6 = g.
package hello_pkg;

    localparam logic [2:0] CH_H     = 3'b000;
    localparam logic [2:0] CH_E     = 3'b001;
    localparam logic [2:0] CH_L     = 3'b010;
    localparam logic [2:0] CH_O     = 3'b011;
    localparam logic [2:0] CH_BLANK = 3'b100;

    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Power-up message "HELLO" followed by blanks.
    function automatic logic [2:0] reset_char(input int i);
        logic [2:0] c;
        c = CH_BLANK;
        case (i)
            0:       c = CH_H;
            1:       c = CH_E;
            2, 3:    c = CH_L;
            4:       c = CH_O;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hello_char_seg.sv
// Combinational decoder from 3-bit character code to 7-bit active-low segments.
// Ports: i_code (char code, 1xx = blank), o_seg (g..a, active low).
module hello_char_seg
    import hello_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_code)
            CH_H:    o_seg = SEG_H;
            CH_E:    o_seg = SEG_E;
            CH_L:    o_seg = SEG_L;
            CH_O:    o_seg = SEG_O;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hello_scroller.sv
// Scrolling message display: writable character buffer shown as a rotating
// window on NUM_DIGITS seven-segment digits.
// Ports: CLOCK_50, reset (sync, active high), load_en/load_addr/load_char
// (buffer write), run (scroll enable), dir (0 left, 1 right),
// hex (registered segments, digit d at hex[7d+6:7d]), pos (offset), step.
module hello_scroller
    import hello_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 25000000,
    parameter int AW         = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [AW-1:0]           load_addr,
    input  logic [2:0]              load_char,
    input  logic                    run,
    input  logic                    dir,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic [AW-1:0]           pos,
    output logic                    step
);

    localparam int              PW       = $clog2(TICK_DIV);
    localparam int              NBUF     = 2 ** AW;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0]   OFF_LAST = AW'(MSG_LEN - 1);

    logic [2:0]              r_buf [NBUF];
    logic [PW-1:0]           r_presc;
    logic [AW-1:0]           r_offset;
    logic                    r_step;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic                    w_tick;
    logic                    w_load_ok;
    logic [AW-1:0]           w_off_nxt;
    logic [7*NUM_DIGITS-1:0] w_hex;

    assign w_tick    = run && (r_presc == PRE_LAST);
    assign w_load_ok = load_en && (int'(load_addr) < MSG_LEN);

    // Offset moves only on a step; dir is looked at only then.
    always_comb begin
        w_off_nxt = r_offset;
        if (w_tick) begin
            if (dir) begin
                w_off_nxt = (r_offset == '0) ? OFF_LAST
                                             : r_offset - AW'(1);
            end else begin
                w_off_nxt = (r_offset == OFF_LAST) ? '0
                                                   : r_offset + AW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_presc  <= '0;
            r_offset <= '0;
            r_step   <= 1'b0;
        end else begin
            r_step   <= w_tick;
            r_offset <= w_off_nxt;
            // Paused prescaler keeps its count so resume is seamless.
            if (run) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < NBUF; i++) begin
                r_buf[i] <= reset_char(i);
            end
        end else if (w_load_ok) begin
            r_buf[load_addr] <= load_char;
        end
    end

    // Digit 0 is rightmost; the leftmost digit shows buffer[offset].
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        localparam int K = NUM_DIGITS - 1 - d;
        logic [AW-1:0] w_idx;
        assign w_idx = AW'((int'(r_offset) + K) % MSG_LEN);
        hello_char_seg u_seg (
            .i_code (r_buf[w_idx]),
            .o_seg  (w_hex[7*d +: 7])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex;
        end
    end

    assign hex  = r_hex;
    assign pos  = r_offset;
    assign step = r_step;

endmodule

// File: tb/tb_hello_scroller.sv
// Directed self-checking bench for hello_scroller.
// Runs with TICK_DIV=4 so scroll steps are four cycles apart.
module tb_hello_scroller;

    localparam int ND = 8;
    localparam int ML = 8;
    localparam int TD = 4;
    localparam int AW = 4;

    localparam logic [2:0] H = 3'd0;
    localparam logic [2:0] E = 3'd1;
    localparam logic [2:0] L = 3'd2;
    localparam logic [2:0] O = 3'd3;
    localparam logic [2:0] B = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [2:0]    load_char;
    logic          run;
    logic          dir;
    logic [7*ND-1:0] hex;
    logic [AW-1:0] pos;
    logic          step;

    int n_tests = 0;
    int n_fail  = 0;
    int n_step;

    hello_scroller #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD),
        .AW         (AW)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_char (load_char),
        .run       (run),
        .dir       (dir),
        .hex       (hex),
        .pos       (pos),
        .step      (step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [2:0] c);
        case (c)
            3'd0:    return 7'b0001001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1000111;
            3'd3:    return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    // codes listed leftmost (digit 7) first
    function automatic logic [7*ND-1:0] disp(input logic [3*ND-1:0] c);
        logic [7*ND-1:0] v;
        v = '0;
        for (int d = 0; d < ND; d++) begin
            v[7*d +: 7] = seg(c[3*d +: 3]);
        end
        return v;
    endfunction

    initial begin
        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_char = 3'd0;
        run       = 1'b0;
        dir       = 1'b0;
        tick();
        tick();
        chk("rst_hex", 64'(hex), 64'({7*ND{1'b1}}));
        chk("rst_pos", 64'(pos), 64'd0);
        chk("rst_step", 64'(step), 64'd0);

        reset = 1'b0;
        tick();
        chk("init_hex", 64'(hex), 64'(disp({H, E, L, L, O, B, B, B})));
        chk("init_pos", 64'(pos), 64'd0);
        chk("init_step", 64'(step), 64'd0);

        // scroll left
        run = 1'b1;
        dir = 1'b0;
        tick();
        tick();
        tick();
        chk("l_nostep", 64'(step), 64'd0);
        tick();
        chk("l_step", 64'(step), 64'd1);
        chk("l_pos1", 64'(pos), 64'd1);
        tick();
        chk("l_step_pulse", 64'(step), 64'd0);
        chk("l_hex1", 64'(hex), 64'(disp({E, L, L, O, B, B, B, H})));
        n_step = 0;
        for (int i = 0; i < 27; i++) begin
            tick();
            if (step) n_step++;
        end
        chk("l_steps", 64'(n_step), 64'd7);
        chk("l_wrap_pos", 64'(pos), 64'd0);

        // scroll right from 0
        dir = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("r_step", 64'(step), 64'd1);
        chk("r_pos7", 64'(pos), 64'd7);
        tick();
        chk("r_hex", 64'(hex), 64'(disp({B, H, E, L, L, O, B, B})));
        tick();

        // pause with prescaler at 2
        run = 1'b0;
        n_step = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) n_step++;
        end
        chk("p_nostep", 64'(n_step), 64'd0);
        chk("p_pos", 64'(pos), 64'd7);
        run = 1'b1;
        tick();
        chk("p_res_nostep", 64'(step), 64'd0);
        tick();
        chk("p_res_step", 64'(step), 64'd1);
        chk("p_res_pos", 64'(pos), 64'd6);

        // two left steps back to 0
        dir = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("back_pos0", 64'(pos), 64'd0);

        // load on the step cycle
        tick();
        tick();
        tick();
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_char = O;
        tick();
        chk("ls_step", 64'(step), 64'd1);
        chk("ls_pos", 64'(pos), 64'd1);
        load_en = 1'b0;
        run     = 1'b0;
        tick();
        chk("ls_hex", 64'(hex), 64'(disp({E, L, L, O, B, B, B, O})));

        // out-of-range write ignored
        load_en   = 1'b1;
        load_addr = 4'd9;
        load_char = H;
        tick();
        load_en = 1'b0;
        tick();
        chk("oor_hex", 64'(hex), 64'(disp({E, L, L, O, B, B, B, O})));

        // write while paused
        load_en   = 1'b1;
        load_addr = 4'd5;
        load_char = E;
        tick();
        load_en = 1'b0;
        tick();
        chk("wr5_hex", 64'(hex), 64'(disp({E, L, L, O, E, B, B, O})));

        // reset mid-scroll
        run = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("m_pos5", 64'(pos), 64'd5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("m_rst_pos", 64'(pos), 64'd0);
        chk("m_rst_hex", 64'(hex), 64'({7*ND{1'b1}}));
        chk("m_rst_step", 64'(step), 64'd0);
        reset = 1'b0;
        tick();
        chk("m_hex", 64'(hex), 64'(disp({H, E, L, L, O, B, B, B})));
        tick();
        tick();
        chk("m_nostep", 64'(step), 64'd0);
        tick();
        chk("m_step", 64'(step), 64'd1);
        chk("m_pos1", 64'(pos), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
